// File: rtl/pattern_scan_pkg.sv
// Shared types, default sizes and the pattern-length clamp for the pattern scan controller.
package pattern_scan_pkg;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 8;
  localparam int DEFAULT_TMO_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  // A zero length still compares one bit; lengths beyond the window saturate.
  function automatic int clamp_len(input int pat_len, input int max_len);
    if (pat_len == 0) return 1;
    else if (pat_len > max_len) return max_len;
    else return pat_len;
  endfunction

endpackage

// File: rtl/pattern_scan_controller_matcher.sv
// Serial shift window with fill counter and a length-masked compare against the loaded pattern.
module pattern_window_matcher #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               a,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   eff_len,
  output logic               match_next
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] window_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   bits_seen;
  logic [LEN_W-1:0]   bits_seen_next;

  // match_next describes the window as it will be after this edge's shift.
  always_comb begin
    window_next    = {window[MAX_LEN-2:0], a};
    bits_seen_next = (bits_seen == LEN_W'(MAX_LEN)) ? bits_seen : bits_seen + LEN_W'(1);
    mask           = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(eff_len));
    match_next     = shift_en && (bits_seen_next >= eff_len) &&
                     (((window_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window    <= '0;
      bits_seen <= '0;
    end else if (clr) begin
      window    <= '0;
      bits_seen <= '0;
    end else if (shift_en) begin
      window    <= window_next;
      bits_seen <= bits_seen_next;
    end
  end

endmodule

// File: rtl/pattern_scan_controller.sv
// Session FSM around the window matcher: load, scan with match/timeout counting, done pulse.
module pattern_scan_controller
  import pattern_scan_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TMO_W   = DEFAULT_TMO_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [MAX_LEN-1:0]           pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic [CNT_W-1:0]             match_target,
  input  logic [TMO_W-1:0]             timeout,
  input  logic                         in_valid,
  input  logic                         a,
  output logic                         busy,
  output logic                         detected,
  output logic [CNT_W-1:0]             match_count,
  output logic                         done,
  output logic                         timed_out
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t             state;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   target_r;
  logic [TMO_W-1:0]   tmo_r;
  logic [TMO_W-1:0]   cyc;

  logic               load_go;
  logic               shift_en;
  logic               match_next;
  logic [CNT_W-1:0]   count_next;
  logic [TMO_W-1:0]   cyc_next;
  logic               hit;
  logic               tmo_hit;

  always_comb begin
    load_go    = (state == IDLE) && start;
    shift_en   = (state == SCAN) && !abort && in_valid;
    count_next = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    cyc_next   = cyc + TMO_W'(1);
    hit        = match_next && (target_r != '0) && (count_next == target_r);
    // A final match on the timeout edge wins over the timeout.
    tmo_hit    = !hit && (tmo_r != '0) && (cyc_next == tmo_r);
  end

  assign busy = (state != IDLE);

  pattern_window_matcher #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_matcher (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_go),
    .shift_en   (shift_en),
    .a          (a),
    .pattern    (pat_r),
    .eff_len    (len_r),
    .match_next (match_next)
  );

  // Configuration is captured with start so it is already stable throughout LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pat_r       <= '0;
      len_r       <= '0;
      target_r    <= '0;
      tmo_r       <= '0;
      cyc         <= '0;
      match_count <= '0;
      detected    <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      detected <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            pat_r       <= pattern;
            len_r       <= LEN_W'(clamp_len(int'(pat_len), MAX_LEN));
            target_r    <= match_target;
            tmo_r       <= timeout;
            cyc         <= '0;
            match_count <= '0;
            timed_out   <= 1'b0;
          end
        end
        LOAD: state <= abort ? IDLE : SCAN;
        SCAN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            cyc <= cyc_next;
            if (match_next) begin
              detected    <= 1'b1;
              match_count <= count_next;
            end
            if (hit || tmo_hit) begin
              state     <= DONE;
              done      <= 1'b1;
              timed_out <= tmo_hit;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
